// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates per issued instruction, captures ALU/LSU
// writebacks, forwards ready results to the decoder and retires one entry per cycle.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             full,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_branch,
    input  logic             alloc_pred_taken,
    input  logic [31:0]      alloc_alt_pc,
    output logic [IDX_W-1:0] alloc_tag,
    input  logic             alu_valid,
    input  logic [IDX_W-1:0] alu_tag,
    input  logic [31:0]      alu_value,
    input  logic             alu_taken,
    input  logic             lsu_valid,
    input  logic [IDX_W-1:0] lsu_tag,
    input  logic [31:0]      lsu_value,
    input  logic [IDX_W-1:0] q1_tag,
    input  logic [IDX_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_value,
    output logic [31:0]      q2_value,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [IDX_W-1:0] commit_tag,
    output logic [31:0]      commit_value,
    output logic             flush,
    output logic [31:0]      redirect_pc
);

    logic [ROB_SIZE-1:0]            busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0]            isbr_q, isbr_d, pred_q, pred_d, taken_q, taken_d;
    logic [ROB_SIZE-1:0][4:0]       rd_q, rd_d;
    logic [ROB_SIZE-1:0][31:0]      value_q, value_d, alt_q, alt_d;
    logic [IDX_W-1:0]               head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]                 count_q, count_d;
    logic                           cvalid_q, cvalid_d, flush_q, flush_d;
    logic [4:0]                     crd_q, crd_d;
    logic [IDX_W-1:0]               ctag_q, ctag_d;
    logic [31:0]                    cvalue_q, cvalue_d, redir_q, redir_d;

    logic alloc_en, commit_en, mispredict, alu_wb, lsu_wb, head_plain;

    assign full      = (count_q == (IDX_W+1)'(ROB_SIZE));
    assign alloc_tag = tail_q;

    // Writebacks only land on live entries and never during the flush cycle.
    assign alloc_en   = rdy & alloc_valid & ~full & ~flush_q;
    assign alu_wb     = rdy & alu_valid & ~flush_q & busy_q[alu_tag];
    assign lsu_wb     = rdy & lsu_valid & ~flush_q & busy_q[lsu_tag];
    assign commit_en  = rdy & busy_q[head_q] & ready_q[head_q] & ~flush_q;
    assign mispredict = commit_en & isbr_q[head_q] & (taken_q[head_q] != pred_q[head_q]);
    assign head_plain = ~isbr_q[head_q];

    always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        isbr_d   = isbr_q;
        pred_d   = pred_q;
        taken_d  = taken_q;
        rd_d     = rd_q;
        value_d  = value_q;
        alt_d    = alt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cvalid_d = cvalid_q;
        crd_d    = crd_q;
        ctag_d   = ctag_q;
        cvalue_d = cvalue_q;
        flush_d  = flush_q;
        redir_d  = redir_q;

        // LSU first so an illegal same-tag collision resolves to the ALU.
        if (lsu_wb) begin
            ready_d[lsu_tag] = 1'b1;
            value_d[lsu_tag] = lsu_value;
        end
        if (alu_wb) begin
            ready_d[alu_tag] = 1'b1;
            value_d[alu_tag] = alu_value;
            taken_d[alu_tag] = alu_taken;
        end
        if (commit_en) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
        end
        if (alloc_en) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            isbr_d[tail_q]  = alloc_is_branch;
            pred_d[tail_q]  = alloc_pred_taken;
            taken_d[tail_q] = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            value_d[tail_q] = 32'd0;
            alt_d[tail_q]   = alloc_alt_pc;
            tail_d          = tail_q + IDX_W'(1);
        end
        case ({alloc_en, commit_en})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (rdy) begin
            cvalid_d = commit_en;
            crd_d    = (commit_en && head_plain) ? rd_q[head_q] : 5'd0;
            cvalue_d = (commit_en && head_plain && rd_q[head_q] != 5'd0) ? value_q[head_q] : 32'd0;
            ctag_d   = commit_en ? head_q : ctag_q;
            flush_d  = mispredict;
            redir_d  = mispredict ? alt_q[head_q] : redir_q;
        end

        // A mispredicted branch discards everything younger, including this cycle's allocation.
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            ready_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= '0;
            ready_q  <= '0;
            isbr_q   <= '0;
            pred_q   <= '0;
            taken_q  <= '0;
            rd_q     <= '0;
            value_q  <= '0;
            alt_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cvalid_q <= 1'b0;
            crd_q    <= '0;
            ctag_q   <= '0;
            cvalue_q <= '0;
            flush_q  <= 1'b0;
            redir_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            isbr_q   <= isbr_d;
            pred_q   <= pred_d;
            taken_q  <= taken_d;
            rd_q     <= rd_d;
            value_q  <= value_d;
            alt_q    <= alt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cvalid_q <= cvalid_d;
            crd_q    <= crd_d;
            ctag_q   <= ctag_d;
            cvalue_q <= cvalue_d;
            flush_q  <= flush_d;
            redir_q  <= redir_d;
        end
    end

    assign commit_valid = cvalid_q;
    assign commit_rd    = crd_q;
    assign commit_tag   = ctag_q;
    assign commit_value = cvalue_q;
    assign flush        = flush_q;
    assign redirect_pc  = redir_q;

    // Operand lookup with same-cycle writeback bypass, ALU taking priority.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = 32'd0;
        if (alu_wb && alu_tag == q1_tag) begin
            q1_ready = 1'b1;
            q1_value = alu_value;
        end else if (lsu_wb && lsu_tag == q1_tag) begin
            q1_ready = 1'b1;
            q1_value = lsu_value;
        end else if (ready_q[q1_tag]) begin
            q1_ready = 1'b1;
            q1_value = value_q[q1_tag];
        end
        q2_ready = 1'b0;
        q2_value = 32'd0;
        if (alu_wb && alu_tag == q2_tag) begin
            q2_ready = 1'b1;
            q2_value = alu_value;
        end else if (lsu_wb && lsu_tag == q2_tag) begin
            q2_ready = 1'b1;
            q2_value = lsu_value;
        end else if (ready_q[q2_tag]) begin
            q2_ready = 1'b1;
            q2_value = value_q[q2_tag];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, writeback, in-order commit,
// misprediction flush, operand query bypass and rdy stall.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, full;
    logic        alloc_valid, alloc_is_branch, alloc_pred_taken;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_alt_pc;
    logic [3:0]  alloc_tag;
    logic        alu_valid, alu_taken, lsu_valid;
    logic [3:0]  alu_tag, lsu_tag, q1_tag, q2_tag;
    logic [31:0] alu_value, lsu_value;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid, flush;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value, redirect_pc;

    int nvec = 0;
    int nerr = 0;

    reorder_buffer #(.ROB_SIZE(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full(full),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc), .alloc_tag(alloc_tag),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_taken(alu_taken),
        .lsu_valid(lsu_valid), .lsu_tag(lsu_tag), .lsu_value(lsu_value),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .commit_value(commit_value), .flush(flush), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_rd = 0; alloc_is_branch = 0; alloc_pred_taken = 0; alloc_alt_pc = 0;
        alu_valid = 0; alu_tag = 0; alu_value = 0; alu_taken = 0;
        lsu_valid = 0; lsu_tag = 0; lsu_value = 0;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1; rst = 0;
        step(); step();
        rst = 1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
        alloc_valid = 1; alloc_rd = rd; alloc_is_branch = br; alloc_pred_taken = pred; alloc_alt_pc = alt;
        step();
        idle();
    endtask

    task automatic test_reset();
        q1_tag = 0; q2_tag = 0;
        do_reset();
        nvec++; if ({commit_valid, commit_rd, commit_tag, commit_value} !== 42'd0) begin
            nerr++; $display("FAIL reset_commit got v=%b rd=%0d tag=%0d val=%h want all 0",
                             commit_valid, commit_rd, commit_tag, commit_value); end
        nvec++; if ({flush, redirect_pc} !== 33'd0) begin
            nerr++; $display("FAIL reset_flush got flush=%b pc=%h want 0", flush, redirect_pc); end
        nvec++; if ({full, alloc_tag} !== 5'd0) begin
            nerr++; $display("FAIL reset_ptr got full=%b tag=%0d want 0/0", full, alloc_tag); end
    endtask

    task automatic test_basic();
        do_reset();
        alloc(5, 0, 0, 0);
        alu_valid = 1; alu_tag = 0; alu_value = 32'h1234; step(); idle();
        nvec++; if (commit_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_early got %b want 0", commit_valid); end
        step();
        nvec++; if ({commit_valid, commit_rd, commit_tag, commit_value} !== {1'b1, 5'd5, 4'd0, 32'h1234}) begin
            nerr++; $display("FAIL basic_commit got v=%b rd=%0d tag=%0d val=%h want 1/5/0/1234",
                             commit_valid, commit_rd, commit_tag, commit_value); end
        step();
        nvec++; if ({commit_valid, commit_rd, commit_value} !== 38'd0) begin
            nerr++; $display("FAIL basic_after got v=%b rd=%0d val=%h want 0", commit_valid, commit_rd, commit_value); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1), 0, 0, 0);
        nvec++; if ({full, alloc_tag} !== {1'b1, 4'd0}) begin
            nerr++; $display("FAIL full_16 got full=%b tag=%0d want 1/0", full, alloc_tag); end
        alloc(20, 0, 0, 0);
        nvec++; if ({full, alloc_tag} !== {1'b1, 4'd0}) begin
            nerr++; $display("FAIL full_17th got full=%b tag=%0d want 1/0", full, alloc_tag); end
        alu_valid = 1; alu_tag = 0; alu_value = 32'hA0; step(); idle();
        nvec++; if ({commit_valid, full} !== 2'b01) begin
            nerr++; $display("FAIL full_wb got v=%b full=%b want 0/1", commit_valid, full); end
        step();
        nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value, full, alloc_tag} !==
                    {1'b1, 4'd0, 5'd1, 32'hA0, 1'b0, 4'd0}) begin
            nerr++; $display("FAIL full_commit got v=%b tag=%0d rd=%0d val=%h full=%b atag=%0d want 1/0/1/a0/0/0",
                             commit_valid, commit_tag, commit_rd, commit_value, full, alloc_tag); end
        alloc(21, 0, 0, 0);
        nvec++; if ({full, alloc_tag} !== {1'b1, 4'd1}) begin
            nerr++; $display("FAIL full_realloc got full=%b tag=%0d want 1/1", full, alloc_tag); end
    endtask

    task automatic test_out_of_order();
        logic [3:0]  etag [3];
        logic [31:0] eval [3];
        etag[0] = 0; etag[1] = 1; etag[2] = 2;
        eval[0] = 32'h10; eval[1] = 32'h11; eval[2] = 32'h22;
        do_reset();
        alloc(1, 0, 0, 0); alloc(2, 0, 0, 0); alloc(3, 0, 0, 0);
        lsu_valid = 1; lsu_tag = 2; lsu_value = 32'h22; step(); idle();
        alu_valid = 1; alu_tag = 1; alu_value = 32'h11; step(); idle();
        nvec++; if (commit_valid !== 1'b0) begin
            nerr++; $display("FAIL ooo_hold got %b want 0", commit_valid); end
        alu_valid = 1; alu_tag = 0; alu_value = 32'h10; step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value} !==
                        {1'b1, etag[i], 5'(i + 1), eval[i]}) begin
                nerr++; $display("FAIL ooo_commit%0d got v=%b tag=%0d rd=%0d val=%h want 1/%0d/%0d/%h",
                                 i, commit_valid, commit_tag, commit_rd, commit_value, etag[i], i + 1, eval[i]); end
        end
    endtask

    task automatic test_branch_ok();
        do_reset();
        alloc(0, 1, 1, 32'h40);
        alloc(0, 0, 0, 0);
        alu_valid = 1; alu_tag = 0; alu_value = 32'h99; alu_taken = 1; step(); idle();
        alu_valid = 1; alu_tag = 1; alu_value = 32'hFFFF; step(); idle();
        nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value, flush} !== {1'b1, 4'd0, 5'd0, 32'd0, 1'b0}) begin
            nerr++; $display("FAIL brok_commit got v=%b tag=%0d rd=%0d val=%h flush=%b want 1/0/0/0/0",
                             commit_valid, commit_tag, commit_rd, commit_value, flush); end
        step();
        nvec++; if ({commit_valid, commit_tag, commit_value, flush} !== {1'b1, 4'd1, 32'd0, 1'b0}) begin
            nerr++; $display("FAIL rd0_commit got v=%b tag=%0d val=%h flush=%b want 1/1/0/0",
                             commit_valid, commit_tag, commit_value, flush); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(7, 0, 0, 0);
        alloc(0, 1, 0, 32'h80);
        alloc(9, 0, 0, 0);
        alu_valid = 1; alu_tag = 1; alu_taken = 1; alu_value = 0; step(); idle();
        alu_valid = 1; alu_tag = 0; alu_value = 32'h5; step(); idle();
        step();
        nvec++; if ({commit_valid, commit_rd, commit_value, flush} !== {1'b1, 5'd7, 32'h5, 1'b0}) begin
            nerr++; $display("FAIL mis_pre got v=%b rd=%0d val=%h flush=%b want 1/7/5/0",
                             commit_valid, commit_rd, commit_value, flush); end
        alloc_valid = 1; alloc_rd = 3; step();
        nvec++; if ({flush, redirect_pc, commit_valid, commit_rd, commit_tag, alloc_tag} !==
                    {1'b1, 32'h80, 1'b1, 5'd0, 4'd1, 4'd0}) begin
            nerr++; $display("FAIL mis_flush got f=%b pc=%h v=%b rd=%0d tag=%0d atag=%0d want 1/80/1/0/1/0",
                             flush, redirect_pc, commit_valid, commit_rd, commit_tag, alloc_tag); end
        alu_valid = 1; alu_tag = 0; alu_value = 32'h77; step(); idle();
        nvec++; if ({flush, commit_valid, alloc_tag, full} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
            nerr++; $display("FAIL mis_after got f=%b v=%b atag=%0d full=%b want 0/0/0/0",
                             flush, commit_valid, alloc_tag, full); end
        for (int i = 0; i < 15; i++) alloc(1, 0, 0, 0);
        nvec++; if (full !== 1'b0) begin
            nerr++; $display("FAIL mis_count15 got full=%b want 0", full); end
        alloc(1, 0, 0, 0);
        nvec++; if (full !== 1'b1) begin
            nerr++; $display("FAIL mis_count16 got full=%b want 1", full); end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 0, 0, 0);
        q1_tag = 3; q2_tag = 2;
        alu_valid = 1; alu_tag = 3; alu_value = 32'hBEEF;
        lsu_valid = 1; lsu_tag = 3; lsu_value = 32'h1111;
        #1;
        nvec++; if ({q1_ready, q1_value} !== {1'b1, 32'hBEEF}) begin
            nerr++; $display("FAIL q_bypass got r=%b v=%h want 1/beef", q1_ready, q1_value); end
        nvec++; if ({q2_ready, q2_value} !== {1'b0, 32'd0}) begin
            nerr++; $display("FAIL q_notready got r=%b v=%h want 0/0", q2_ready, q2_value); end
        step(); idle();
        nvec++; if ({q1_ready, q1_value} !== {1'b1, 32'hBEEF}) begin
            nerr++; $display("FAIL q_stored got r=%b v=%h want 1/beef", q1_ready, q1_value); end
        lsu_valid = 1; lsu_tag = 2; lsu_value = 32'h77;
        #1;
        nvec++; if ({q2_ready, q2_value} !== {1'b1, 32'h77}) begin
            nerr++; $display("FAIL q_lsu_bypass got r=%b v=%h want 1/77", q2_ready, q2_value); end
        step(); idle();
        q1_tag = 0; q2_tag = 0;
    endtask

    task automatic test_stall();
        do_reset();
        alloc(4, 0, 0, 0); alloc(6, 0, 0, 0);
        alu_valid = 1; alu_tag = 0; alu_value = 32'h44;
        lsu_valid = 1; lsu_tag = 1; lsu_value = 32'h66;
        step(); idle();
        step();
        nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 4'd0, 5'd4, 32'h44}) begin
            nerr++; $display("FAIL stall_first got v=%b tag=%0d rd=%0d val=%h want 1/0/4/44",
                             commit_valid, commit_tag, commit_rd, commit_value); end
        rdy = 0; alloc_valid = 1; alloc_rd = 9;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value, alloc_tag} !==
                        {1'b1, 4'd0, 5'd4, 32'h44, 4'd2}) begin
                nerr++; $display("FAIL stall_hold%0d got v=%b tag=%0d rd=%0d val=%h atag=%0d want 1/0/4/44/2",
                                 i, commit_valid, commit_tag, commit_rd, commit_value, alloc_tag); end
        end
        rdy = 1; idle(); step();
        nvec++; if ({commit_valid, commit_tag, commit_rd, commit_value} !== {1'b1, 4'd1, 5'd6, 32'h66}) begin
            nerr++; $display("FAIL stall_resume got v=%b tag=%0d rd=%0d val=%h want 1/1/6/66",
                             commit_valid, commit_tag, commit_rd, commit_value); end
        step();
        nvec++; if ({commit_valid, commit_rd, commit_value} !== 38'd0) begin
            nerr++; $display("FAIL stall_drain got v=%b rd=%0d val=%h want 0", commit_valid, commit_rd, commit_value); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_branch_ok();
        test_mispredict();
        test_query();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between the decoder/issue stage and the register file.
- Allocates one entry per issued instruction and captures results from the ALU and LSU writeback buses.
- Forwards ready results to the decoder for operand lookup.
- Retires at most one instruction per cycle onto the register file commit port; on branch misprediction it raises a one-cycle flush with a redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- IDX_W, 4, log2(ROB_SIZE), tag width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-low reset
- rdy  input  1  global enable; when 0, all state holds
- full  output  1  asserted when count == ROB_SIZE
- alloc_valid  input  1  allocate an entry this cycle
- alloc_rd  input  5  destination register; 0 means no destination
- alloc_is_branch  input  1  entry is a conditional branch
- alloc_pred_taken  input  1  predicted direction
- alloc_alt_pc  input  32  PC to fetch from if the prediction proves wrong
- alloc_tag  output  IDX_W  tag the next allocation receives (= tail, combinational)
- alu_valid  input  1  ALU writeback
- alu_tag  input  IDX_W  ALU writeback tag
- alu_value  input  32  ALU writeback value
- alu_taken  input  1  ALU actual branch direction
- lsu_valid  input  1  LSU writeback
- lsu_tag  input  IDX_W  LSU writeback tag
- lsu_value  input  32  LSU writeback value
- q1_tag, q2_tag  input  IDX_W  operand tags queried by the decoder
- q1_ready, q2_ready  output  1  queried result available (combinational)
- q1_value, q2_value  output  32  queried result (combinational)
- commit_valid  output  1  registered, one retirement this cycle
- commit_rd  output  5  register to write
- commit_tag  output  IDX_W  tag of the retiring entry
- commit_value  output  32  value to write
- flush  output  1  registered misprediction flush pulse
- redirect_pc  output  32  fetch PC, valid while flush = 1

Behaviour:
- Reset (rst = 0 at posedge):
  - head = tail = count = 0; all busy/ready bits cleared.
  - commit_valid = 0, commit_rd = 0, commit_tag = 0, commit_value = 0.
  - flush = 0, redirect_pc = 0.
  - Reset overrides every other input, including mid-flush.
- Entry fields: busy, ready, rd, value, is_branch, pred_taken, taken, alt_pc.
- Allocation:
  - Occurs when alloc_valid & ~full & ~flush.
  - Writes fields with busy = 1, ready = 0; tail advances modulo ROB_SIZE.
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - Each valid port sets ready = 1 and writes value at its tag; ALU also writes taken.
  - Both ports on distinct tags in the same cycle are both captured.
  - Same tag on both ports is illegal; ALU wins.
  - Writeback to a non-busy entry is ignored.
- Commit:
  - Evaluated each cycle on the head entry; occurs if busy & ready & ~flush.
  - Head advances and busy clears; outputs are registered, so commit_valid is high in the cycle after the edge that retires.
  - Latency: writeback at edge N, entry ready after N, commit_valid high after edge N+1.
  - Non-commit cycles drive commit_valid = 0, commit_rd = 0, commit_value = 0.
  - commit_value is forced to 0 when rd = 0.
  - A branch commits with commit_rd = 0.
- count: +1 on allocate, −1 on commit; both in one cycle leaves it unchanged. When full, a commit frees a slot and full drops the next cycle.
- Misprediction:
  - Triggered when the committing head is a branch with taken ≠ pred_taken.
  - On the same edge, flush <= 1 and redirect_pc <= alt_pc; head, tail and count reset to 0 and all busy bits clear.
  - While flush = 1, alloc and writeback inputs are ignored; flush drops after one cycle.
  - A correctly predicted branch commits silently.
- Query:
  - qN_ready = 1 if entry[qN_tag] is ready, or a same-cycle ALU/LSU writeback matches qN_tag (bypass; ALU has priority).
  - qN_value is the matching value when ready, else 0.
- Wrap-around: head and tail wrap at ROB_SIZE − 1 → 0. full and empty are distinguished by count, never by pointer equality.
- rdy = 0: no allocation, writeback or commit; all registers, including commit outputs, hold their values.

Test Plan:
- Reset, then allocate rd = 5 (tag 0), ALU writeback tag 0 value 0x1234 -> two edges later commit_valid = 1, commit_rd = 5, commit_tag = 0, commit_value = 0x1234; then commit_valid = 0.
- Allocate 16 entries, no writebacks -> full = 1 and a 17th allocation leaves tail = 0; writeback tag 0 -> tag 0 commits, full = 0 next cycle, next allocation gets tag 0.
- Out-of-order completion on tags 0,1,2 (LSU tag 2 first, ALU tag 1, ALU tag 0) -> commits appear in order 0,1,2 on consecutive cycles.
- Branch at tag 1 with pred_taken = 0, alu_taken = 1, alt_pc = 0x80 -> after tag 0 commits, flush = 1 for one cycle with redirect_pc = 0x80, commit_rd = 0; afterwards count = 0 and alloc_tag = 0.
- q1_tag = 3 while ALU writeback tag 3 value 0xBEEF -> q1_ready = 1, q1_value = 0xBEEF in the same cycle; for a non-ready tag -> q1_ready = 0, q1_value = 0.
- Hold rdy = 0 for 3 cycles during a pending commit -> no state change; commit resumes with the same values once rdy = 1.
